debug_trace_ctrl: RTL

DEBUG_TRACE_CTRL -- requirements
Module: debug_trace_ctrl

---
 rtl/debug_trace_ctrl_if.sv | 25 ++
 rtl/debug_trace_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/debug_trace_ctrl_if.sv
// Snapshot capture and trace readout channels of debug_trace_ctrl.
// The slave side is the trace controller; the master side is the pipeline debug port plus reader.
interface debug_trace_ctrl_if;
    logic        snap_valid;
    logic [31:0] snap_data;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output snap_valid,
        output snap_data,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  snap_valid,
        input  snap_data,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/debug_trace_ctrl.sv
// Trigger-based circular trace buffer with post-trigger capture and oldest-first readout; optional halt via DEBUG_TRACE_HALT_EN.
// Latency: a captured word is readable one cycle after the write that completes capture (state DONE).
// Backpressure: readout holds rd_data until rd_ready; capture never stalls, and overwrites the oldest entry when full.
module debug_trace_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [31:0]       trig_value,
    input  logic [31:0]       trig_mask,
    input  logic [AW-1:0]     post_count,
    debug_trace_ctrl_if.slave bus,
    output logic [1:0]        state_o,
    output logic [AW:0]       count_o,
    output logic              triggered_o,
    output logic              core_stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t          state_q, state_n;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_n;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_n;
    logic [AW:0]     count_q, count_n;
    logic [AW-1:0]   remaining_q, remaining_n;
    logic            wr_en;
    logic            hit;
    logic            rd_valid_int;
    logic [31:0]     mem [DEPTH];

    assign hit          = bus.snap_valid && (((bus.snap_data ^ trig_value) & trig_mask) == 32'd0);
    assign rd_valid_int = (state_q == DONE) && (count_q != '0);

    always_comb begin
        state_n     = state_q;
        wr_ptr_n    = wr_ptr_q;
        rd_ptr_n    = rd_ptr_q;
        count_n     = count_q;
        remaining_n = remaining_q;
        wr_en       = 1'b0;

        // arm restarts from any state and wins over a same-cycle write or read
        if (arm) begin
            state_n     = ARMED;
            wr_ptr_n    = '0;
            count_n     = '0;
            remaining_n = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (bus.snap_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr_q + PTR_ONE;
                        count_n  = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
                        if (hit) begin
                            remaining_n = post_count;
                            state_n     = (post_count == '0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (bus.snap_valid) begin
                        wr_en       = 1'b1;
                        wr_ptr_n    = wr_ptr_q + PTR_ONE;
                        count_n     = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
                        remaining_n = remaining_q - PTR_ONE;
                        if (remaining_q == PTR_ONE) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    if (rd_valid_int && bus.rd_ready) begin
                        rd_ptr_n = rd_ptr_q + PTR_ONE;
                        count_n  = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            // A full buffer truncates count to zero here, which correctly lands on wr_ptr
            if (state_n == DONE && state_q != DONE) begin
                rd_ptr_n = wr_ptr_n - count_n[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_n;
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            count_q     <= count_n;
            remaining_q <= remaining_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.snap_data;
        end
    end

    assign bus.rd_valid = rd_valid_int;
    assign bus.rd_data  = mem[rd_ptr_q];
    assign state_o      = state_q;
    assign count_o      = count_q;
    assign triggered_o  = (state_q == POST) || (state_q == DONE);

`ifdef DEBUG_TRACE_HALT_EN
    assign core_stall_o = (state_q == DONE);
`else
    assign core_stall_o = 1'b0;
`endif

endmodule
